// File: rtl/regfile_wb_if.sv
// Write-back bus between two result sources (ALU, LSU) and the register-file arbiter.
// The master modport is the source/observer side; the slave modport is the arbiter.
interface regfile_wb_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
);
  logic                  src0_valid;
  logic                  src0_ready;
  logic [DEPTH_LOG2-1:0] src0_addr;
  logic [WIDTH-1:0]      src0_data;
  logic                  src1_valid;
  logic                  src1_ready;
  logic [DEPTH_LOG2-1:0] src1_addr;
  logic [WIDTH-1:0]      src1_data;
  logic                  rd_write;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [WIDTH-1:0]      rd_wdata;
  logic                  idle;

  modport master (
    output src0_valid, src0_addr, src0_data,
    output src1_valid, src1_addr, src1_data,
    input  src0_ready, src1_ready,
    input  rd_write, rd_addr, rd_wdata, idle
  );

  modport slave (
    input  src0_valid, src0_addr, src0_data,
    input  src1_valid, src1_addr, src1_data,
    output src0_ready, src1_ready,
    output rd_write, rd_addr, rd_wdata, idle
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Two-source write-back arbiter: per-source 2-entry FIFOs feeding one registered rd_* port.
// Define REGFILE_WB_RR_EN for round-robin contention; default is fixed priority to source 0.
module regfile_wb_arbiter #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic           clk,
  input  logic           rst,
  regfile_wb_if.slave    bus
);

  typedef struct packed {
    logic [DEPTH_LOG2-1:0] addr;
    logic [WIDTH-1:0]      data;
  } entry_t;

  // Handshake: an entry transfers on a rising edge where srcN_valid && srcN_ready;
  // srcN_ready comes from registered occupancy only, so a full FIFO refuses even while popping.
  entry_t                mem_q   [2][2];
  logic   [1:0]          cnt_q   [2];
  logic   [1:0]          cnt_d   [2];
  logic                  wptr_q  [2];
  logic                  rptr_q  [2];
  entry_t                in_entry[2];
  logic   [1:0]          in_valid;
  logic   [1:0]          ready;
  logic   [1:0]          push;
  logic   [1:0]          pop;
  logic   [1:0]          nonempty;
  logic                  gnt_valid;
  logic                  gnt_src;
  logic                  prio;
  entry_t                head;
  logic                  rd_write_q;
  logic [DEPTH_LOG2-1:0] rd_addr_q;
  logic [WIDTH-1:0]      rd_wdata_q;

  assign in_valid    = {bus.src1_valid, bus.src0_valid};
  assign in_entry[0] = {bus.src0_addr, bus.src0_data};
  assign in_entry[1] = {bus.src1_addr, bus.src1_data};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ready[i]    = ~cnt_q[i][1];
      push[i]     = in_valid[i] & ready[i];
      nonempty[i] = (cnt_q[i] != 2'd0);
    end
  end

  always_comb begin
    gnt_valid = |nonempty;
    gnt_src   = 1'b0;
    if (nonempty[0] && nonempty[1]) begin
      gnt_src = prio;
    end else if (nonempty[1]) begin
      gnt_src = 1'b1;
    end
    pop = 2'b00;
    if (gnt_valid) begin
      pop[gnt_src] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_d[i] = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
    end
  end

  assign head = mem_q[gnt_src][rptr_q[gnt_src]];

`ifdef REGFILE_WB_RR_EN
  logic prio_q;

  // After each grant the other source gets first claim on the next contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (gnt_valid) begin
      prio_q <= ~gnt_src;
    end
  end

  assign prio = prio_q;
`else
  assign prio = 1'b0;
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_q[i][wptr_q[i]] <= in_entry[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i]  <= 2'd0;
        wptr_q[i] <= 1'b0;
        rptr_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (push[i]) wptr_q[i] <= ~wptr_q[i];
        if (pop[i])  rptr_q[i] <= ~rptr_q[i];
      end
    end
  end

  // Register 0 is hardwired: its entries are consumed without a write and rd_* hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_write_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_wdata_q <= '0;
    end else begin
      rd_write_q <= gnt_valid && (head.addr != '0);
      if (gnt_valid && (head.addr != '0)) begin
        rd_addr_q  <= head.addr;
        rd_wdata_q <= head.data;
      end
    end
  end

  assign bus.src0_ready = ready[0];
  assign bus.src1_ready = ready[1];
  assign bus.rd_write   = rd_write_q;
  assign bus.rd_addr    = rd_addr_q;
  assign bus.rd_wdata   = rd_wdata_q;
  assign bus.idle       = (cnt_q[0] == 2'd0) && (cnt_q[1] == 2'd0) && !rd_write_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter; expected orders follow REGFILE_WB_RR_EN when defined.
module tb_regfile_wb_arbiter;
  localparam int W = 32;
  localparam int A = 4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  int   cyc;

  logic [A-1:0]   log_addr[$];
  logic [W-1:0]   log_data[$];
  int             log_cyc[$];
  logic [A+W-1:0] exp0_q[$];
  logic [A+W-1:0] exp1_q[$];

  regfile_wb_if #(.WIDTH(W), .DEPTH_LOG2(A)) bus ();

  regfile_wb_arbiter #(.WIDTH(W), .DEPTH_LOG2(A)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && bus.rd_write) begin
      log_addr.push_back(bus.rd_addr);
      log_data.push_back(bus.rd_wdata);
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [A-1:0] a, input logic [W-1:0] d);
    bus.src0_valid = v;
    bus.src0_addr  = a;
    bus.src0_data  = d;
  endtask

  task automatic drive1(input logic v, input logic [A-1:0] a, input logic [W-1:0] d);
    bus.src1_valid = v;
    bus.src1_addr  = a;
    bus.src1_data  = d;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic test_reset();
    tick();
    n_vec++; if (bus.rd_write !== 1'b0) begin n_err++; $display("FAIL rst_hold_write: got %0b expected 0", bus.rd_write); end
    n_vec++; if ({bus.src0_ready, bus.src1_ready} !== 2'b11) begin n_err++; $display("FAIL rst_hold_ready: got %b expected 11", {bus.src0_ready, bus.src1_ready}); end
    n_vec++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL rst_hold_idle: got %0b expected 1", bus.idle); end
    rst = 1'b0;
    drive0(1'b1, 4'd9, 32'h5555_AAAA);
    drive1(1'b1, 4'd11, 32'h0000_1111);
    tick();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    tick();
    n_vec++; if (bus.rd_write !== 1'b1 || bus.rd_addr !== 4'd9) begin n_err++; $display("FAIL pre_rst_write: got %0b/%0h expected 1/9", bus.rd_write, bus.rd_addr); end
    #3;
    rst = 1'b1;
    clear_log();
    #1;
    n_vec++; if (bus.rd_write !== 1'b0) begin n_err++; $display("FAIL async_rst_write: got %0b expected 0", bus.rd_write); end
    n_vec++; if (bus.rd_addr !== 4'd0) begin n_err++; $display("FAIL async_rst_addr: got %0h expected 0", bus.rd_addr); end
    n_vec++; if (bus.rd_wdata !== 32'd0) begin n_err++; $display("FAIL async_rst_wdata: got %0h expected 0", bus.rd_wdata); end
    n_vec++; if ({bus.src0_ready, bus.src1_ready} !== 2'b11) begin n_err++; $display("FAIL async_rst_ready: got %b expected 11", {bus.src0_ready, bus.src1_ready}); end
    n_vec++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL async_rst_idle: got %0b expected 1", bus.idle); end
    tick();
    rst = 1'b0;
    repeat (3) tick();
    n_vec++; if (log_addr.size() != 0) begin n_err++; $display("FAIL async_rst_discard: got %0d writes expected 0", log_addr.size()); end
  endtask

  task automatic test_single_write();
    drive0(1'b1, 4'd5, 32'hDEAD_BEEF);
    tick();
    drive0(1'b0, '0, '0);
    n_vec++; if (bus.rd_write !== 1'b0) begin n_err++; $display("FAIL single_early: got %0b expected 0", bus.rd_write); end
    tick();
    n_vec++; if (bus.rd_write !== 1'b1) begin n_err++; $display("FAIL single_write: got %0b expected 1", bus.rd_write); end
    n_vec++; if (bus.rd_addr !== 4'd5) begin n_err++; $display("FAIL single_addr: got %0h expected 5", bus.rd_addr); end
    n_vec++; if (bus.rd_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_wdata: got %0h expected deadbeef", bus.rd_wdata); end
    tick();
    n_vec++; if (bus.rd_write !== 1'b0) begin n_err++; $display("FAIL single_one_cycle: got %0b expected 0", bus.rd_write); end
    n_vec++; if (bus.rd_addr !== 4'd5) begin n_err++; $display("FAIL single_hold_addr: got %0h expected 5", bus.rd_addr); end
    n_vec++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL single_idle: got %0b expected 1", bus.idle); end
  endtask

  task automatic test_x0_drop();
    drive1(1'b1, 4'd0, 32'h0000_1234);
    tick();
    drive1(1'b0, '0, '0);
    n_vec++; if (bus.idle !== 1'b0) begin n_err++; $display("FAIL x0_busy: got %0b expected 0", bus.idle); end
    tick();
    n_vec++; if (bus.rd_write !== 1'b0) begin n_err++; $display("FAIL x0_write: got %0b expected 0", bus.rd_write); end
    n_vec++; if (bus.rd_addr !== 4'd5 || bus.rd_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL x0_hold: got %0h/%0h expected 5/deadbeef", bus.rd_addr, bus.rd_wdata); end
    n_vec++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL x0_idle: got %0b expected 1", bus.idle); end
    n_vec++; if (bus.src1_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready: got %0b expected 1", bus.src1_ready); end
  endtask

  task automatic test_contention();
    logic [A-1:0] ea[4];
    logic [W-1:0] ed[4];
    int start;
`ifdef REGFILE_WB_RR_EN
    ea[0] = 4'd1; ea[1] = 4'd3; ea[2] = 4'd2; ea[3] = 4'd4;
    ed[0] = 32'hA0; ed[1] = 32'hB0; ed[2] = 32'hA1; ed[3] = 32'hB1;
`else
    ea[0] = 4'd1; ea[1] = 4'd2; ea[2] = 4'd3; ea[3] = 4'd4;
    ed[0] = 32'hA0; ed[1] = 32'hA1; ed[2] = 32'hB0; ed[3] = 32'hB1;
`endif
    clear_log();
    start = cyc;
    drive0(1'b1, 4'd1, 32'hA0);
    drive1(1'b1, 4'd3, 32'hB0);
    tick();
    drive0(1'b1, 4'd2, 32'hA1);
    drive1(1'b1, 4'd4, 32'hB1);
    tick();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    repeat (6) tick();
    n_vec++; if (log_addr.size() != 4) begin n_err++; $display("FAIL cont_count: got %0d expected 4", log_addr.size()); end
    if (log_addr.size() == 4) begin
      n_vec++; if (log_cyc[0] != start + 2) begin n_err++; $display("FAIL cont_latency: got cycle %0d expected %0d", log_cyc[0], start + 2); end
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (log_addr[i] !== ea[i] || log_data[i] !== ed[i] || log_cyc[i] != log_cyc[0] + i) begin
          n_err++;
          $display("FAIL cont_order[%0d]: got %0h/%0h@%0d expected %0h/%0h@%0d", i, log_addr[i], log_data[i], log_cyc[i], ea[i], ed[i], log_cyc[0] + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int i0;
    int k1;
    logic r0;
    logic r1;
    logic [A+W-1:0] e;
    clear_log();
    exp0_q.delete();
    exp1_q.delete();
    i0 = 0;
    k1 = 0;
    r1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive0(1'b1, 4'(1 + (i0 % 9)), 32'hA000 + 32'(i0));
      drive1(1'b1, 4'(10 + (k1 % 6)), 32'hB000 + 32'(k1));
      r0 = bus.src0_ready;
      r1 = bus.src1_ready;
      tick();
      if (r0) begin exp0_q.push_back({4'(1 + (i0 % 9)), 32'hA000 + 32'(i0)}); i0++; end
      if (r1) begin exp1_q.push_back({4'(10 + (k1 % 6)), 32'hB000 + 32'(k1)}); k1++; end
    end
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    repeat (12) tick();
`ifndef REGFILE_WB_RR_EN
    n_vec++; if (k1 != 2) begin n_err++; $display("FAIL bp_src1_accepts: got %0d expected 2", k1); end
    n_vec++; if (r1 !== 1'b0) begin n_err++; $display("FAIL bp_src1_ready: got %0b expected 0", r1); end
    n_vec++; if (i0 != 8) begin n_err++; $display("FAIL bp_src0_accepts: got %0d expected 8", i0); end
`endif
    for (int i = 0; i < log_addr.size(); i++) begin
      n_vec++;
      if (log_addr[i] >= 4'd10) begin
        if (exp1_q.size() == 0) begin n_err++; $display("FAIL bp_src1_dup: got %0h/%0h expected none", log_addr[i], log_data[i]); end
        else begin
          e = exp1_q.pop_front();
          if ({log_addr[i], log_data[i]} !== e) begin n_err++; $display("FAIL bp_src1_data: got %0h expected %0h", {log_addr[i], log_data[i]}, e); end
        end
      end else begin
        if (exp0_q.size() == 0) begin n_err++; $display("FAIL bp_src0_dup: got %0h/%0h expected none", log_addr[i], log_data[i]); end
        else begin
          e = exp0_q.pop_front();
          if ({log_addr[i], log_data[i]} !== e) begin n_err++; $display("FAIL bp_src0_data: got %0h expected %0h", {log_addr[i], log_data[i]}, e); end
        end
      end
    end
    n_vec++; if (exp0_q.size() != 0 || exp1_q.size() != 0) begin n_err++; $display("FAIL bp_lost: got %0d/%0d left expected 0/0", exp0_q.size(), exp1_q.size()); end
  endtask

  task automatic test_reset_midflight();
    clear_log();
    drive0(1'b1, 4'd6, 32'h61);
    drive1(1'b1, 4'd12, 32'hC1);
    tick();
    drive0(1'b1, 4'd7, 32'h62);
    drive1(1'b1, 4'd13, 32'hC2);
    tick();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    #3;
    rst = 1'b1;
    clear_log();
    #1;
    n_vec++; if (bus.rd_write !== 1'b0) begin n_err++; $display("FAIL mid_rst_write: got %0b expected 0", bus.rd_write); end
    tick();
    rst = 1'b0;
    repeat (4) tick();
    n_vec++; if (log_addr.size() != 0) begin n_err++; $display("FAIL mid_rst_discard: got %0d writes expected 0", log_addr.size()); end
    n_vec++; if (bus.idle !== 1'b1) begin n_err++; $display("FAIL mid_rst_idle: got %0b expected 1", bus.idle); end
    drive1(1'b1, 4'd14, 32'h0E0E);
    tick();
    drive1(1'b0, '0, '0);
    n_vec++; if (bus.rd_write !== 1'b0) begin n_err++; $display("FAIL mid_rst_early: got %0b expected 0", bus.rd_write); end
    tick();
    n_vec++; if (bus.rd_write !== 1'b1 || bus.rd_addr !== 4'd14 || bus.rd_wdata !== 32'h0E0E) begin n_err++; $display("FAIL mid_rst_latency: got %0b/%0h/%0h expected 1/e/e0e", bus.rd_write, bus.rd_addr, bus.rd_wdata); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    test_reset();
    test_single_write();
    test_x0_drop();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of every write-back word.
REQ-002 Parameter DEPTH_LOG2, default 4, register address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 src0_valid  input  1  source 0 (ALU) offers a write-back.
REQ-006 src0_ready  output  1  source 0 entry can be accepted this cycle.
REQ-007 src0_addr  input  DEPTH_LOG2  source 0 destination register.
REQ-008 src0_data  input  WIDTH  source 0 write data.
REQ-009 src1_valid  input  1  source 1 (LSU) offers a write-back.
REQ-010 src1_ready  output  1  source 1 entry can be accepted this cycle.
REQ-011 src1_addr  input  DEPTH_LOG2  source 1 destination register.
REQ-012 src1_data  input  WIDTH  source 1 write data.
REQ-013 rd_write  output  1  register-file write strobe, registered.
REQ-014 rd_addr  output  DEPTH_LOG2  register-file write address, registered.
REQ-015 rd_wdata  output  WIDTH  register-file write data, registered.
REQ-016 idle  output  1  high when both queues are empty and rd_write is low.

Function
REQ-017 Each source SHALL own a 2-entry FIFO of {addr,data}; srcN_ready SHALL be high iff that FIFO's registered occupancy is below 2.
REQ-018 A transfer SHALL occur on a rising edge where srcN_valid and srcN_ready are both high; the entry is pushed at that edge.
REQ-019 srcN_ready SHALL NOT depend combinationally on srcN_valid or on the same-cycle pop, so a full FIFO refuses a push even while popping.
REQ-020 Each cycle, if at least one FIFO is non-empty, exactly one head SHALL be granted and popped at the next edge.
REQ-021 A granted entry with addr != 0 SHALL drive rd_write=1, rd_addr, rd_wdata for exactly the one cycle after the pop edge.
REQ-022 A granted entry with addr == 0 SHALL be popped with rd_write=0, and rd_addr/rd_wdata held.
REQ-023 Latency SHALL be 2 cycles: an entry accepted at edge k into an empty, uncontested FIFO drives rd_write in the cycle after edge k+1.
REQ-024 Throughput SHALL be one write per cycle with no bubble under continuous contention.
REQ-025 When no grant occurs, rd_write SHALL be 0 and rd_addr/rd_wdata SHALL hold their previous values.
REQ-026 Entries from the same source SHALL reach rd_* in acceptance order.
REQ-027 idle SHALL be combinational from registered state only.

Reset
REQ-028 While rst is high: FIFOs empty, src0_ready=src1_ready=1, rd_write=0, rd_addr=0, rd_wdata=0, idle=1, and the priority pointer selects source 0.
REQ-029 rst asserted mid-operation SHALL discard all queued entries immediately, with no write issued for them.

Configuration
REQ-030 With macro REGFILE_WB_RR_EN defined, contention SHALL be round-robin: the pointer toggles to the other source after every grant, and reset favours source 0.
REQ-031 Without REGFILE_WB_RR_EN, source 0 SHALL always win contention (fixed priority), and source 1 is granted only when source 0's FIFO is empty.

Verification
REQ-032 Reset check: assert rst asynchronously mid-cycle -> rd_write=0, rd_addr=0, rd_wdata=0, both ready=1, idle=1 with no clock edge.
REQ-033 Single write: src0 pushes addr=5, data=0xDEADBEEF at edge 1 -> rd_write=1, rd_addr=5, rd_wdata=0xDEADBEEF only in the cycle after edge 2.
REQ-034 x0 drop: src1 pushes addr=0, data=0x1234 -> its FIFO drains, rd_write stays 0, and idle returns to 1 two cycles later.
REQ-035 Contention with RR_EN: both sources push two entries (A0,A1 / B0,B1) at once -> write order A0,B0,A1,B1 on 4 consecutive cycles; without the macro the order is A0,A1,B0,B1.
REQ-036 Backpressure: hold src1_valid high with the output stalled by continuous src0 traffic (no RR) -> src1_ready falls after 2 accepts and no src1 entry is lost or duplicated.
REQ-037 Reset mid-flight: assert rst with 3 entries queued -> no rd_write pulse follows, and the next accepted entry writes with 2-cycle latency.
